// File: rtl/svram_access_sched_if.sv
// ---------------------------------------------------------------------------
// svram_access_sched_if
// Request/response bus between the slow-VRAM access scheduler and the SDRAM
// controller that backs slow VRAM.
//
// Signals:
//   SDR_REQ     request level, held until SDR_ACK
//   SDR_WE      1 = 16-bit write, 0 = 32-bit read
//   SDR_ADDR    request word address
//   SDR_WDATA   write data
//   SDR_ACK     one-clock accept (completion for writes)
//   SDR_RVALID  one-clock read-data strobe
//   SDR_RDATA   read data {word[addr+1], word[addr]}
//
// Modports:
//   master  scheduler side
//   slave   SDRAM controller side
// ---------------------------------------------------------------------------
interface svram_access_sched_if #(
    parameter int ADDR_W = 15
);
    logic              SDR_REQ;
    logic              SDR_WE;
    logic [ADDR_W-1:0] SDR_ADDR;
    logic [15:0]       SDR_WDATA;
    logic              SDR_ACK;
    logic              SDR_RVALID;
    logic [31:0]       SDR_RDATA;

    modport master (
        output SDR_REQ, SDR_WE, SDR_ADDR, SDR_WDATA,
        input  SDR_ACK, SDR_RVALID, SDR_RDATA
    );

    modport slave (
        input  SDR_REQ, SDR_WE, SDR_ADDR, SDR_WDATA,
        output SDR_ACK, SDR_RVALID, SDR_RDATA
    );
endinterface

// File: rtl/svram_access_sched.sv
// ---------------------------------------------------------------------------
// svram_access_sched
// Schedules slow-VRAM slots from the LSPC cycle generator onto the SDRAM
// controller. Fix-map, sprite-map and CPU-read slots become 32-bit SDRAM
// reads; CPU writes are queued in a small FIFO and drained whenever no read
// is pending. Late reads (LATE) and dropped writes (WOVF) are sticky flags.
//
// Optional feature macro: SVRAM_WRFWD_EN
//   When defined, a CPU read whose address matches the newest queued write
//   is answered from the FIFO ({16'h0000, data}) without an SDRAM access.
//
// Ports:
//   CLK_24M         master clock, rising edge
//   RESETP          synchronous active-high reset
//   SLOT_START      one-clock pulse at the start of each slot
//   VRAM_CYCLE      00 fix read, 01 CPU R/W, 10 sprite-map read, 11 idle
//   SVRAM_ADDR      slot word address
//   BWE             active-low CPU write strobe (01 slots only)
//   SVRAM_DATA_OUT  CPU write data
//   SVRAM_DATA_IN   read data returned to the LSPC
//   RD_DONE         one-clock pulse when SVRAM_DATA_IN updates
//   LATE            sticky: slot started while a read was outstanding
//   WOVF            sticky: CPU write dropped, FIFO full
//   FLAG_CLR        clears LATE and WOVF (a simultaneous set wins)
//   WFIFO_LEVEL     write FIFO occupancy
//   sdr             SDRAM request bus (master side)
// ---------------------------------------------------------------------------
module svram_access_sched #(
    parameter  int WFIFO_DEPTH = 4,
    parameter  int ADDR_W      = 15,
    localparam int PTR_W       = $clog2(WFIFO_DEPTH),
    localparam int LVL_W       = PTR_W + 1
) (
    input  logic              CLK_24M,
    input  logic              RESETP,
    input  logic              SLOT_START,
    input  logic [1:0]        VRAM_CYCLE,
    input  logic [ADDR_W-1:0] SVRAM_ADDR,
    input  logic              BWE,
    input  logic [15:0]       SVRAM_DATA_OUT,
    output logic [31:0]       SVRAM_DATA_IN,
    output logic              RD_DONE,
    output logic              LATE,
    output logic              WOVF,
    input  logic              FLAG_CLR,
    output logic [LVL_W-1:0]  WFIFO_LEVEL,
    svram_access_sched_if.master sdr
);

    // state   | meaning
    // IDLE    | nothing on the SDRAM bus; pick a pending read, else a write
    // RD_REQ  | 32-bit read requested at the pending address, wait ACK
    // RD_WAIT | read accepted, wait RVALID to return the data
    // WR_REQ  | FIFO head write requested, wait ACK (never aborted)
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    state_t            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
    logic [15:0]       fifo_data_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_done_q, rd_done_d;
    logic              late_q, late_d;
    logic              wovf_q, wovf_d;

    logic slot_rd, slot_wr, fifo_full, fifo_empty, push, pop, fwd_hit, rd_load;

`ifdef SVRAM_WRFWD_EN
    logic             fwd_vld_q, fwd_vld_d;
    logic [15:0]      fwd_data_q, fwd_data_d;
    logic [PTR_W-1:0] newest;
`endif

    always_comb begin
        slot_rd    = SLOT_START && ((VRAM_CYCLE == 2'b00) || (VRAM_CYCLE == 2'b10) ||
                                    ((VRAM_CYCLE == 2'b01) && BWE));
        slot_wr    = SLOT_START && (VRAM_CYCLE == 2'b01) && !BWE;
        fifo_full  = (level_q == LVL_W'(WFIFO_DEPTH));
        fifo_empty = (level_q == '0);
        push       = slot_wr && !fifo_full;
        pop        = (state_q == WR_REQ) && sdr.SDR_ACK;
`ifdef SVRAM_WRFWD_EN
        newest     = wptr_q - 1'b1;
        fwd_hit    = slot_rd && (VRAM_CYCLE == 2'b01) && !fifo_empty &&
                     (fifo_addr_q[newest] == SVRAM_ADDR);
`else
        fwd_hit    = 1'b0;
`endif
        rd_load    = slot_rd && !fwd_hit;
    end

    always_comb begin
        state_d       = state_q;
        pend_vld_d    = pend_vld_q;
        pend_addr_d   = pend_addr_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        level_d       = level_q;
        rdata_d       = rdata_q;
        rd_done_d     = 1'b0;
        late_d        = late_q;
        wovf_d        = wovf_q;
        sdr.SDR_REQ   = 1'b0;
        sdr.SDR_WE    = 1'b0;
        sdr.SDR_ADDR  = '0;
        sdr.SDR_WDATA = '0;
`ifdef SVRAM_WRFWD_EN
        fwd_vld_d     = fwd_vld_q;
        fwd_data_d    = fwd_data_q;
`endif

        case (state_q)
            IDLE: begin
                // A read slot arriving this clock blocks a write start so the
                // read does not queue behind a fresh write.
                if (pend_vld_q)
                    state_d = RD_REQ;
                else if (!rd_load && !fifo_empty)
                    state_d = WR_REQ;
            end
            RD_REQ: begin
                sdr.SDR_REQ  = 1'b1;
                sdr.SDR_ADDR = pend_addr_q;
                if (sdr.SDR_ACK) begin
                    pend_vld_d = 1'b0;
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (sdr.SDR_RVALID) begin
                    rdata_d   = sdr.SDR_RDATA;
                    rd_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            WR_REQ: begin
                sdr.SDR_REQ   = 1'b1;
                sdr.SDR_WE    = 1'b1;
                sdr.SDR_ADDR  = fifo_addr_q[rptr_q];
                sdr.SDR_WDATA = fifo_data_q[rptr_q];
                if (sdr.SDR_ACK)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SVRAM_WRFWD_EN
        // Forwarded data yields to a real read return in the same clock.
        if (fwd_vld_q && !rd_done_d) begin
            rdata_d   = {16'h0000, fwd_data_q};
            rd_done_d = 1'b1;
            fwd_vld_d = 1'b0;
        end
        if (fwd_hit) begin
            fwd_vld_d  = 1'b1;
            fwd_data_d = fifo_data_q[newest];
        end
`endif

        // New slot read overrides both an unissued read and an ACK clear.
        if (rd_load) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = SVRAM_ADDR;
        end

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (FLAG_CLR) begin
            late_d = 1'b0;
            wovf_d = 1'b0;
        end
        if (SLOT_START && ((state_q == RD_REQ) || (state_q == RD_WAIT) || pend_vld_q))
            late_d = 1'b1;
        if (slot_wr && fifo_full)
            wovf_d = 1'b1;
    end

    always_ff @(posedge CLK_24M) begin
        if (RESETP) begin
            state_q     <= IDLE;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            rdata_q     <= '0;
            rd_done_q   <= 1'b0;
            late_q      <= 1'b0;
            wovf_q      <= 1'b0;
`ifdef SVRAM_WRFWD_EN
            fwd_vld_q   <= 1'b0;
            fwd_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            rdata_q     <= rdata_d;
            rd_done_q   <= rd_done_d;
            late_q      <= late_d;
            wovf_q      <= wovf_d;
`ifdef SVRAM_WRFWD_EN
            fwd_vld_q   <= fwd_vld_d;
            fwd_data_q  <= fwd_data_d;
`endif
        end
    end

    // FIFO storage needs no reset: it is only read behind a non-zero level.
    always_ff @(posedge CLK_24M) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= SVRAM_ADDR;
            fifo_data_q[wptr_q] <= SVRAM_DATA_OUT;
        end
    end

    assign SVRAM_DATA_IN = rdata_q;
    assign RD_DONE       = rd_done_q;
    assign LATE          = late_q;
    assign WOVF          = wovf_q;
    assign WFIFO_LEVEL   = level_q;

endmodule

// File: tb/tb_svram_access_sched.sv
module tb_svram_access_sched;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } sdr_txn_t;

    logic        clk;
    logic        rst;
    logic        slot_start;
    logic [1:0]  vram_cycle;
    logic [14:0] svram_addr;
    logic        bwe;
    logic [15:0] dout;
    logic [31:0] data_in;
    logic        rd_done;
    logic        late;
    logic        wovf;
    logic        flag_clr;
    logic [2:0]  level;

    svram_access_sched_if #(.ADDR_W(15)) sdr_if ();

    svram_access_sched #(.WFIFO_DEPTH(4), .ADDR_W(15)) dut (
        .CLK_24M        (clk),
        .RESETP         (rst),
        .SLOT_START     (slot_start),
        .VRAM_CYCLE     (vram_cycle),
        .SVRAM_ADDR     (svram_addr),
        .BWE            (bwe),
        .SVRAM_DATA_OUT (dout),
        .SVRAM_DATA_IN  (data_in),
        .RD_DONE        (rd_done),
        .LATE           (late),
        .WOVF           (wovf),
        .FLAG_CLR       (flag_clr),
        .WFIFO_LEVEL    (level),
        .sdr            (sdr_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rd_done_cnt = 0;

    sdr_txn_t    exp_sdr_q [$];
    logic [31:0] exp_data_q [$];

    int          ack_dly     = 1;
    int          rv_dly      = 2;
    int          req_cnt     = 0;
    int          rv_cnt      = 0;
    bit          ack_hold    = 0;
    bit          expect_data = 1;
    logic [31:0] rd_word     = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // SDRAM responder: ACK on the ack_dly-th cycle of REQ, RVALID rv_dly
    // cycles after a read ACK. Each accepted request is checked against the
    // scoreboard.
    initial begin
        sdr_txn_t e;
        sdr_if.SDR_ACK    = 1'b0;
        sdr_if.SDR_RVALID = 1'b0;
        sdr_if.SDR_RDATA  = '0;
        forever begin
            @(posedge clk); #1;
            sdr_if.SDR_ACK    = 1'b0;
            sdr_if.SDR_RVALID = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    sdr_if.SDR_RVALID = 1'b1;
                    sdr_if.SDR_RDATA  = rd_word;
                    if (expect_data) exp_data_q.push_back(rd_word);
                end
            end
            if (sdr_if.SDR_REQ && !ack_hold) begin
                req_cnt++;
                if (req_cnt >= ack_dly) begin
                    req_cnt = 0;
                    sdr_if.SDR_ACK = 1'b1;
                    if (exp_sdr_q.size() == 0) begin
                        check_val("sdr_unexp_req", {16'h0, sdr_if.SDR_WDATA}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_sdr_q.pop_front();
                        check_val("sdr_we", 32'(sdr_if.SDR_WE), 32'(e.we));
                        check_val("sdr_addr", 32'(sdr_if.SDR_ADDR), 32'(e.addr));
                        if (e.we) check_val("sdr_wdata", 32'(sdr_if.SDR_WDATA), 32'(e.wdata));
                    end
                    if (!sdr_if.SDR_WE) rv_cnt = rv_dly;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    // Read-return monitor
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rd_done) begin
                rd_done_cnt++;
                if (exp_data_q.size() == 0)
                    check_val("rd_done_unexp", data_in, 32'hXXXX_XXXF ^ data_in);
                else
                    check_val("rd_data", data_in, exp_data_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic slot(input logic [1:0] cyc, input logic [14:0] a, input logic b, input logic [15:0] d);
        slot_start = 1'b1;
        vram_cycle = cyc;
        svram_addr = a;
        bwe        = b;
        dout       = d;
        step(1);
        slot_start = 1'b0;
        vram_cycle = 2'b11;
        bwe        = 1'b1;
    endtask

    task automatic push_sdr(input logic we, input logic [14:0] a, input logic [15:0] d);
        sdr_txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        exp_sdr_q.push_back(t);
    endtask

    task automatic wait_req(input logic lvl, input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (sdr_if.SDR_REQ === lvl) break;
            step(1);
        end
        if (i == max) check_val("wait_req_timeout", 32'(sdr_if.SDR_REQ), 32'(lvl));
    endtask

    task automatic wait_drain(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            if (exp_sdr_q.size() == 0 && exp_data_q.size() == 0 && rv_cnt == 0 &&
                !sdr_if.SDR_REQ && !sdr_if.SDR_RVALID) break;
            step(1);
        end
        if (i == max) check_val("drain_timeout", 32'(exp_sdr_q.size() + exp_data_q.size()), 32'd0);
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        step(1);
        flag_clr = 1'b0;
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        slot_start = 1'b0;
        vram_cycle = 2'b11;
        svram_addr = '0;
        bwe        = 1'b1;
        dout       = '0;
        flag_clr   = 1'b0;
        step(3);

        // Reset values
        check_val("rst_data_in", data_in, 32'h0);
        check_val("rst_rd_done", 32'(rd_done), 32'h0);
        check_val("rst_req", 32'(sdr_if.SDR_REQ), 32'h0);
        check_val("rst_we", 32'(sdr_if.SDR_WE), 32'h0);
        check_val("rst_addr", 32'(sdr_if.SDR_ADDR), 32'h0);
        check_val("rst_wdata", 32'(sdr_if.SDR_WDATA), 32'h0);
        check_val("rst_late", 32'(late), 32'h0);
        check_val("rst_wovf", 32'(wovf), 32'h0);
        check_val("rst_level", 32'(level), 32'h0);
        rst = 1'b0;
        step(1);

        // Reset while in RD_WAIT, then a stray RVALID
        expect_data = 0;
        ack_dly = 1; rv_dly = 8; rd_word = 32'hDEADBEEF;
        push_sdr(1'b0, 15'h0011, 16'h0);
        slot(2'b00, 15'h0011, 1'b1, 16'h0);
        wait_req(1'b1, 20);
        wait_req(1'b0, 20);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(8);
        check_val("rstw_data_in", data_in, 32'h0);
        check_val("rstw_rd_done_cnt", 32'(rd_done_cnt), 32'h0);
        check_val("rstw_req", 32'(sdr_if.SDR_REQ), 32'h0);
        check_val("rstw_late", 32'(late), 32'h0);
        expect_data = 1;

        // Fix read: ACK on 3rd REQ clock, RVALID 4 clocks later
        ack_dly = 3; rv_dly = 4; rd_word = 32'h12345678;
        base = rd_done_cnt;
        push_sdr(1'b0, 15'h7012, 16'h0);
        slot(2'b00, 15'h7012, 1'b1, 16'h0);
        check_val("fix_req_early", 32'(sdr_if.SDR_REQ), 32'h0);
        step(1);
        check_val("fix_req_latency", 32'(sdr_if.SDR_REQ), 32'h1);
        check_val("fix_addr", 32'(sdr_if.SDR_ADDR), 32'h7012);
        check_val("fix_we", 32'(sdr_if.SDR_WE), 32'h0);
        wait_drain(100);
        step(2);
        check_val("fix_data_in", data_in, 32'h12345678);
        check_val("fix_rd_done_cnt", 32'(rd_done_cnt - base), 32'h1);
        check_val("fix_late", 32'(late), 32'h0);

        // FIFO overflow: five writes into a depth-4 FIFO with ACK held off
        ack_dly = 1; ack_hold = 1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_sdr(1'b1, 15'(i), 16'(8'hA0 + i));
            slot(2'b01, 15'(i), 1'b0, 16'(8'hA0 + i));
        end
        check_val("ovf_level", 32'(level), 32'h4);
        check_val("ovf_wovf", 32'(wovf), 32'h1);
        check_val("ovf_late", 32'(late), 32'h0);
        step(3);
        check_val("ovf_level_hold", 32'(level), 32'h4);
        ack_hold = 0;
        wait_drain(200);
        check_val("ovf_level_empty", 32'(level), 32'h0);
        check_val("ovf_wovf_sticky", 32'(wovf), 32'h1);
        pulse_clr();
        check_val("ovf_wovf_clr", 32'(wovf), 32'h0);

        // Read priority over a just-queued write
        ack_dly = 2; rv_dly = 3; rd_word = 32'hCAFE0200;
        push_sdr(1'b0, 15'h0200, 16'h0);
        push_sdr(1'b1, 15'h0300, 16'h5A5A);
        slot(2'b01, 15'h0300, 1'b0, 16'h5A5A);
        slot(2'b10, 15'h0200, 1'b1, 16'h0);
        step(1);
        check_val("prio_req", 32'(sdr_if.SDR_REQ), 32'h1);
        check_val("prio_we", 32'(sdr_if.SDR_WE), 32'h0);
        check_val("prio_addr", 32'(sdr_if.SDR_ADDR), 32'h0200);
        wait_drain(200);
        check_val("prio_late", 32'(late), 32'h0);
        check_val("prio_level", 32'(level), 32'h0);

        // LATE: slot during RD_WAIT, with FLAG_CLR in the same clock
        ack_dly = 1; rv_dly = 6; rd_word = 32'h0BADF00D;
        base = rd_done_cnt;
        push_sdr(1'b0, 15'h0040, 16'h0);
        slot(2'b00, 15'h0040, 1'b1, 16'h0);
        wait_req(1'b1, 20);
        wait_req(1'b0, 20);
        flag_clr = 1'b1;
        slot(2'b11, 15'h0000, 1'b1, 16'h0);
        flag_clr = 1'b0;
        check_val("late_set_wins", 32'(late), 32'h1);
        pulse_clr();
        check_val("late_clr", 32'(late), 32'h0);
        wait_drain(100);
        step(2);
        check_val("late_data_in", data_in, 32'h0BADF00D);
        check_val("late_rd_done_cnt", 32'(rd_done_cnt - base), 32'h1);

        // CPU read of a queued write address (write in WR_REQ, ACK held)
        ack_dly = 1; rv_dly = 2; ack_hold = 1;
        push_sdr(1'b1, 15'h0100, 16'hBEEF);
        slot(2'b01, 15'h0100, 1'b0, 16'hBEEF);
        step(2);
`ifdef SVRAM_WRFWD_EN
        exp_data_q.push_back(32'h0000BEEF);
        slot(2'b01, 15'h0100, 1'b1, 16'h0);
        step(1);
        check_val("fwd_rd_done", 32'(rd_done), 32'h1);
        check_val("fwd_data_in", data_in, 32'h0000BEEF);
        check_val("fwd_late", 32'(late), 32'h0);
`else
        rd_word = 32'h11110100;
        push_sdr(1'b0, 15'h0100, 16'h0);
        slot(2'b01, 15'h0100, 1'b1, 16'h0);
        step(1);
        check_val("cpurd_write_held", 32'(sdr_if.SDR_WE), 32'h1);
        check_val("cpurd_late", 32'(late), 32'h0);
`endif
        ack_hold = 0;
        wait_drain(200);
        step(2);
        check_val("end_level", 32'(level), 32'h0);
        check_val("end_scoreboard", 32'(exp_sdr_q.size() + exp_data_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/svram_access_sched.md
Name: svram_access_sched

Overview:
- Scheduler between the LSPC slow-VRAM cycle generator and the SDRAM controller backing slow VRAM (fix map, sprite map, CPU-visible low VRAM).
- Per slow-VRAM slot it issues a 32-bit read for fix-map, sprite-map and CPU-read slots, and returns the data on SVRAM_DATA_IN.
- CPU writes are buffered in a small FIFO and drained into SDRAM whenever no display or CPU read is pending.
- Late reads and FIFO overflow are flagged.

Parameters:
- WFIFO_DEPTH, 4, CPU write FIFO entries (power of two, 2..16).
- ADDR_W, 15, slow-VRAM word address width.

Ports:
- CLK_24M  in  1  master clock; all logic on rising edge.
- RESETP  in  1  synchronous active-high reset.
- SLOT_START  in  1  one-clock pulse at the start of each slow-VRAM slot.
- VRAM_CYCLE  in  2  slot type: 00 fix read, 01 CPU R/W, 10 sprite-map read, 11 idle.
- SVRAM_ADDR  in  15  slot word address.
- BWE  in  1  active-low CPU write strobe; sampled only in 01 slots.
- SVRAM_DATA_OUT  in  16  CPU write data.
- SVRAM_DATA_IN  out  32  read data {word[addr+1], word[addr]}.
- RD_DONE  out  1  one-clock pulse when SVRAM_DATA_IN updates.
- SDR_REQ  out  1  request to SDRAM; level, held until SDR_ACK.
- SDR_WE  out  1  1 = write, 0 = 32-bit read; stable while SDR_REQ is high.
- SDR_ADDR  out  15  request word address.
- SDR_WDATA  out  16  write data.
- SDR_ACK  in  1  one-clock accept; on a write, this also means completion.
- SDR_RVALID  in  1  one-clock read-data strobe (at least 1 clock after ACK).
- SDR_RDATA  in  32  read data.
- LATE  out  1  sticky: a slot started while a read was still outstanding.
- WOVF  out  1  sticky: CPU write dropped because the FIFO was full.
- FLAG_CLR  in  1  clears LATE and WOVF.
- WFIFO_LEVEL  out  log2(WFIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: every output is 0; FIFO empty; FSM in IDLE; pending-read slot empty.
- Slot capture: on SLOT_START, latch VRAM_CYCLE, SVRAM_ADDR, BWE and SVRAM_DATA_OUT.
  - 00, 10, or 01 with BWE=1: load the read-pending slot (1 deep).
  - 01 with BWE=0: push {addr, data} into the FIFO.
  - 11: no new work.
- FSM states:
  - IDLE: if a read is pending, go to RD_REQ; else if the FIFO is non-empty, go to WR_REQ.
  - RD_REQ: SDR_REQ=1, SDR_WE=0, SDR_ADDR=pending addr. On SDR_ACK, clear the pending slot and go to RD_WAIT.
  - RD_WAIT: on SDR_RVALID, SVRAM_DATA_IN<=SDR_RDATA, pulse RD_DONE, go to IDLE.
  - WR_REQ: SDR_REQ=1, SDR_WE=1, address and data from the FIFO head. On SDR_ACK, pop the FIFO and go to IDLE.
- Priority: reads always win over starting a write. A write already in WR_REQ is never aborted; a read arriving meanwhile waits for its ACK.
- Latency: read request asserted on the 2nd clock after SLOT_START when IDLE. SVRAM_DATA_IN updates on the SDR_RVALID clock and holds otherwise.
- LATE: SLOT_START while in RD_REQ or RD_WAIT, or while the pending slot is occupied, sets LATE.
  - An already-pending unissued read is overwritten by the new slot's read; the in-flight read still completes.
- FIFO full + write slot: entry dropped, WOVF set, occupancy unchanged.
- Push and pop in the same clock: level unchanged. Pointers wrap modulo WFIFO_DEPTH.
- FLAG_CLR coinciding with a set event: the set wins.
- SDR_RVALID outside RD_WAIT: ignored.

Optional Feature:
- Macro: SVRAM_WRFWD_EN.
- Defined: a CPU read (01, BWE=1) whose address matches the newest FIFO entry takes no SDRAM access.
  - SVRAM_DATA_IN <= {16'h0000, forwarded data}; RD_DONE pulses 2 clocks after SLOT_START.
  - Only the newest entry is compared.
- Undefined: every CPU read goes to SDRAM, which may return stale data while matching writes are still queued.

Test Plan:
- Reset mid-RD_WAIT, then SDR_RVALID=1 with RDATA=32'hDEADBEEF → SVRAM_DATA_IN stays 0, no RD_DONE, SDR_REQ=0.
- Fix slot, addr 15'h7012, ACK on 3rd clock, RVALID 4 clocks later with 32'h12345678 → SDR_ADDR=7012, SDR_WE=0; SVRAM_DATA_IN=12345678; one RD_DONE pulse; LATE=0.
- Five 01/BWE=0 slots (addr 0..4, data 0xA0..0xA4) with ACK held low; WFIFO_DEPTH=4 → WFIFO_LEVEL=4, WOVF=1; after ACKs, SDRAM sees writes addr 0..3 in order and data 0xA4 never appears.
- Write queued, then sprite slot addr 15'h0200 before the write is requested → read issued first; write follows after RVALID.
- Second SLOT_START while in RD_WAIT → LATE=1; FLAG_CLR clears it; the first read's data is still delivered.
- (SVRAM_WRFWD_EN) Write addr 15'h0100, data 16'hBEEF, then CPU read of 0100 → SVRAM_DATA_IN=32'h0000BEEF with no SDR read request.
